wallace_mac: RTL and testbench
==============================

WALLACE_MAC -- requirements
Module: wallace_mac

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Parameter GUARD, default 4, accumulator guard bits; legal range 0..8.
REQ-003 Derived: PROD_W = 2*WIDTH; ACC_W = PROD_W + GUARD.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ena  in  1  global enable; low = whole pipeline stalls and holds.
REQ-007 in_valid  in  1  operands and controls valid this cycle.
REQ-008 in_a, in_b  in  WIDTH each  multiplicand, multiplier.
REQ-009 signed_mode  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 acc_en  in  1  1 = add product into accumulator, 0 = pass product.
REQ-011 acc_clr  in  1  with acc_en, load product into accumulator instead of adding.
REQ-012 out_valid  out  1  out_result valid this cycle.
REQ-013 out_result  out  ACC_W  product or accumulator value, extended per signed_mode.
REQ-014 overflow  out  1  sticky accumulator overflow flag.

Function
REQ-015 Stage 1 registers in_a, in_b, signed_mode, acc_en, acc_clr and in_valid when ena=1.
REQ-016 Stage 2 registers the PROD_W-bit Wallace-tree product of the stage-1 operands (Baugh-Wooley when signed_mode=1).
REQ-017 Stage 3 registers out_result and out_valid; latency is exactly 3 enabled cycles from in_valid to out_valid.
REQ-018 One new operation accepted per enabled cycle; no back-pressure; bubbles (in_valid=0) propagate as out_valid=0.
REQ-019 ena=0 freezes every pipeline register, accumulator, out_valid and overflow; outputs hold their previous values.
REQ-020 acc_en=0: out_result = product extended to ACC_W (sign-extend if signed, else zero-extend); accumulator unchanged.
REQ-021 acc_en=1, acc_clr=0: accumulator <= accumulator + extended product; out_result = new accumulator value.
REQ-022 acc_en=1, acc_clr=1: accumulator <= extended product (old value discarded, overflow cleared); out_result = that value.
REQ-023 acc_clr with acc_en=0 is ignored.
REQ-024 Accumulator wraps modulo 2^ACC_W; overflow set when the true sum is unrepresentable in ACC_W bits under the stage's signed_mode; stays set until acc_clr+acc_en or reset.
REQ-025 Mixing signed_mode between accumulating operations is legal; each add uses its own operation's signedness for extension and overflow detection.
REQ-026 Accumulator updates only on valid stage-2 operations; bubbles never modify it.

Reset
REQ-027 rst_n low asynchronously clears all valid bits, out_valid=0, out_result=0, accumulator=0, overflow=0.
REQ-028 Reset mid-operation discards all in-flight operations; first out_valid after release is 3 enabled cycles after the first accepted in_valid.

Structure
REQ-029 Package wallace_pkg holds default WIDTH/GUARD, derived-width functions and the stage-control bundle typedef.
REQ-030 One combinational sub-module wallace_tree_mul (parametrised WIDTH, signed_mode input) builds the partial-product reduction tree from half/full adder cells plus final carry-propagate adder.
REQ-031 wallace_mac contains only the pipeline registers, accumulator and overflow logic around it.

Verification (WIDTH=4, GUARD=4)
REQ-032 Unsigned 15x15, acc_en=0 -> out_valid 3 cycles later, out_result=225 (0x0E1), overflow=0.
REQ-033 Signed -8x-8 then -8x7, acc_en=0 -> out_result 64 (0x040) then -56 (0xFC8) on consecutive cycles.
REQ-034 Back-to-back 3x5 acc_clr, 2x2, 1x1 with acc_en=1 -> out_result 15, 19, 20 on three consecutive cycles.
REQ-035 Unsigned 15x15 accumulated 19 times from acc_clr -> 19th sum 4275 wraps to 179 (0x0B3), overflow=1 and stays 1 until next acc_clr.
REQ-036 ena held low 2 cycles with 2 operations in flight -> outputs frozen, results emerge in order after 2 extra cycles.
REQ-037 rst_n pulsed low with 3 operations in flight -> out_valid=0, out_result=0, accumulator=0 immediately; no stale result after release.

Source files
------------

// File: rtl/wallace_pkg.sv
// Shared definitions for the Wallace-tree multiply-accumulate pipeline.
//   DEF_WIDTH / DEF_GUARD : default operand width and accumulator guard bits
//   prod_w / acc_w        : derived product and accumulator widths
//   tree_stages           : reduction-stage bound for the partial-product tree
//   stage_ctrl_t          : per-stage control bundle carried alongside operands
package wallace_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_GUARD = 4;

    // Full-precision product width.
    function automatic int unsigned prod_w(input int unsigned width);
        return 2 * width;
    endfunction

    // Accumulator width: product plus guard bits.
    function automatic int unsigned acc_w(input int unsigned width, input int unsigned guard);
        return 2 * width + guard;
    endfunction

    // Every non-final reduction stage contains at least one full adder, which
    // removes one bit from the matrix, so the initial bit count bounds the stages.
    function automatic int unsigned tree_stages(input int unsigned width);
        return width * width + 2;
    endfunction

    typedef struct packed {
        logic valid;
        logic signed_mode;
        logic acc_en;
        logic acc_clr;
    } stage_ctrl_t;

endpackage

// File: rtl/wallace_tree_mul.sv
// Combinational WIDTH x WIDTH multiplier: partial-product matrix (Baugh-Wooley
// when signed_mode=1) reduced by half/full adder layers to two rows, then a
// ripple carry-propagate adder.
//   a, b        : multiplicand, multiplier
//   signed_mode : 1 = two's-complement operands, 0 = unsigned
//   product_c   : 2*WIDTH-bit product (modulo 2^(2*WIDTH))
module wallace_tree_mul
    import wallace_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic [2*WIDTH-1:0] product_c
);

    localparam int unsigned PW     = prod_w(WIDTH);
    // Column heights never exceed WIDTH; HW pads for the k+2 read of a full adder.
    localparam int unsigned HMAX   = WIDTH + 2;
    localparam int unsigned HW     = HMAX + 2;
    localparam int unsigned STAGES = tree_stages(WIDTH);

    // Full adder cell: {carry, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    // Half adder cell: {carry, sum}.
    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [HW-1:0] col  [PW];
    int            cnt  [PW];
    logic [HW-1:0] nxt  [PW];
    int            ncnt [PW];

    always_comb begin : reduce
        logic [1:0] r;
        logic       pp;
        logic       carry;

        r         = '0;
        pp        = 1'b0;
        carry     = 1'b0;
        product_c = '0;
        for (int c = 0; c < PW; c++) begin
            col[c]  = '0;
            cnt[c]  = 0;
            nxt[c]  = '0;
            ncnt[c] = 0;
        end

        // Partial products; terms pairing exactly one operand MSB are inverted
        // in signed mode, compensated by the constant ones at columns WIDTH and PW-1.
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp = (a[j] & b[i]) ^ (signed_mode & ((i == WIDTH - 1) != (j == WIDTH - 1)));
                col[i+j][cnt[i+j]] = pp;
                cnt[i+j]++;
            end
        end
        col[WIDTH][cnt[WIDTH]] = signed_mode;
        cnt[WIDTH]++;
        col[PW-1][cnt[PW-1]] = signed_mode;
        cnt[PW-1]++;

        // Wallace layers: columns taller than two are compressed 3:2 / 2:2,
        // shorter columns pass through; carries out of the top column are dropped.
        for (int s = 0; s < STAGES; s++) begin
            for (int c = 0; c < PW; c++) begin
                nxt[c]  = '0;
                ncnt[c] = 0;
            end
            for (int c = 0; c < PW; c++) begin
                if (cnt[c] > 2) begin
                    for (int k = 0; k < HMAX; k += 3) begin
                        if (k + 2 < cnt[c]) begin
                            r = fa(col[c][k], col[c][k+1], col[c][k+2]);
                        end else if (k + 1 < cnt[c]) begin
                            r = ha(col[c][k], col[c][k+1]);
                        end else begin
                            r = {1'b0, col[c][k]};
                        end
                        if (k < cnt[c]) begin
                            nxt[c][ncnt[c]] = r[0];
                            ncnt[c]++;
                            if ((k + 1 < cnt[c]) && (c + 1 < PW)) begin
                                nxt[c+1][ncnt[c+1]] = r[1];
                                ncnt[c+1]++;
                            end
                        end
                    end
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        if (k < cnt[c]) begin
                            nxt[c][ncnt[c]] = col[c][k];
                            ncnt[c]++;
                        end
                    end
                end
            end
            for (int c = 0; c < PW; c++) begin
                col[c] = nxt[c];
                cnt[c] = ncnt[c];
            end
        end

        // Final carry-propagate adder over the two remaining rows.
        for (int c = 0; c < PW; c++) begin
            r            = fa(col[c][0], col[c][1], carry);
            product_c[c] = r[0];
            carry        = r[1];
        end
    end

endmodule

// File: rtl/wallace_mac.sv
// Three-stage multiply-accumulate pipeline around wallace_tree_mul.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ena                 : global enable; low freezes every register
//   in_valid            : operation present on the inputs
//   in_a, in_b          : WIDTH-bit operands
//   signed_mode         : 1 = two's-complement, 0 = unsigned
//   acc_en, acc_clr     : accumulate / load-accumulator controls
//   out_valid           : out_result carries a result this cycle
//   out_result          : extended product or new accumulator value
//   overflow            : sticky accumulator overflow
module wallace_mac
    import wallace_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned GUARD = DEF_GUARD
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_a,
    input  logic [WIDTH-1:0]               in_b,
    input  logic                           signed_mode,
    input  logic                           acc_en,
    input  logic                           acc_clr,
    output logic                           out_valid,
    output logic [acc_w(WIDTH, GUARD)-1:0] out_result,
    output logic                           overflow
);

    localparam int unsigned PROD_W = prod_w(WIDTH);
    localparam int unsigned ACC_W  = acc_w(WIDTH, GUARD);

    stage_ctrl_t       s1_ctrl;
    stage_ctrl_t       s2_ctrl;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;
    logic [PROD_W-1:0] prod_c;
    logic [PROD_W-1:0] s2_prod;
    logic [ACC_W-1:0]  acc;

    logic [ACC_W-1:0]  ext_c;
    logic [ACC_W:0]    sum_c;
    logic              add_ovf_c;
    logic [ACC_W-1:0]  acc_nxt_c;
    logic [ACC_W-1:0]  res_nxt_c;
    logic              ovf_nxt_c;

    // Stage 1: capture operands and controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ctrl <= '0;
            s1_a    <= '0;
            s1_b    <= '0;
        end else if (ena) begin
            s1_ctrl <= '{valid: in_valid, signed_mode: signed_mode,
                         acc_en: acc_en, acc_clr: acc_clr};
            s1_a    <= in_a;
            s1_b    <= in_b;
        end
    end

    wallace_tree_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .a           (s1_a),
        .b           (s1_b),
        .signed_mode (s1_ctrl.signed_mode),
        .product_c   (prod_c)
    );

    // Stage 2: register the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_ctrl <= '0;
            s2_prod <= '0;
        end else if (ena) begin
            s2_ctrl <= s1_ctrl;
            s2_prod <= prod_c;
        end
    end

    // Product extension and accumulate add with per-operation overflow rule.
    always_comb begin
        ext_c = ACC_W'(s2_prod);
        if (s2_ctrl.signed_mode && s2_prod[PROD_W-1]) begin
            ext_c = ext_c | ~ACC_W'({PROD_W{1'b1}});
        end
        sum_c = {1'b0, acc} + {1'b0, ext_c};
        if (s2_ctrl.signed_mode) begin
            add_ovf_c = (acc[ACC_W-1] == ext_c[ACC_W-1]) && (sum_c[ACC_W-1] != acc[ACC_W-1]);
        end else begin
            add_ovf_c = sum_c[ACC_W];
        end
    end

    // Stage-3 next values; bubbles leave accumulator, result and flag untouched.
    always_comb begin
        acc_nxt_c = acc;
        res_nxt_c = out_result;
        ovf_nxt_c = overflow;
        if (s2_ctrl.valid) begin
            if (!s2_ctrl.acc_en) begin
                res_nxt_c = ext_c;
            end else if (s2_ctrl.acc_clr) begin
                acc_nxt_c = ext_c;
                res_nxt_c = ext_c;
                ovf_nxt_c = 1'b0;
            end else begin
                acc_nxt_c = sum_c[ACC_W-1:0];
                res_nxt_c = sum_c[ACC_W-1:0];
                ovf_nxt_c = overflow | add_ovf_c;
            end
        end
    end

    // Stage 3: outputs, accumulator and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            acc        <= '0;
            overflow   <= 1'b0;
        end else if (ena) begin
            out_valid  <= s2_ctrl.valid;
            out_result <= res_nxt_c;
            acc        <= acc_nxt_c;
            overflow   <= ovf_nxt_c;
        end
    end

endmodule

// File: tb/tb_wallace_mac.sv
// Scoreboard bench for wallace_mac (WIDTH=4, GUARD=4): directed operations push
// hand-computed results with their expected enabled-cycle stamp; a monitor pops
// and compares whenever a fresh out_valid appears.
module tb_wallace_mac;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned GUARD = 4;
    localparam int unsigned ACC_W = 2 * WIDTH + GUARD;

    typedef struct {
        logic [ACC_W-1:0] res;
        logic             ovf;
        int               stamp;
        int               id;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             signed_mode;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic [ACC_W-1:0] out_result;
    logic             overflow;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ecnt    = 0;
    int   op_id   = 0;
    logic fresh   = 1'b0;

    always #5 clk = ~clk;

    wallace_mac #(
        .WIDTH (WIDTH),
        .GUARD (GUARD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .signed_mode (signed_mode),
        .acc_en      (acc_en),
        .acc_clr     (acc_clr),
        .out_valid   (out_valid),
        .out_result  (out_result),
        .overflow    (overflow)
    );

    // Count enabled edges; fresh marks an edge that may have produced a new output.
    always @(posedge clk) begin
        fresh <= ena && rst_n;
        if (ena && rst_n) ecnt <= ecnt + 1;
    end

    // Monitor: pop and compare on each new valid output.
    always @(negedge clk) begin
        if (fresh && out_valid) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got out_result=0x%03h at cycle %0d, required no output",
                         out_result, ecnt);
            end else begin
                e = sb.pop_front();
                if (out_result !== e.res || overflow !== e.ovf || ecnt != e.stamp) begin
                    n_fail++;
                    $display("FAIL op%0d: got res=0x%03h ovf=%0b cycle=%0d, required res=0x%03h ovf=%0b cycle=%0d",
                             e.id, out_result, overflow, ecnt, e.res, e.ovf, e.stamp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic sm, input logic ae, input logic ac,
                      input logic [ACC_W-1:0] er, input logic eo);
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        in_a        = a;
        in_b        = b;
        signed_mode = sm;
        acc_en      = ae;
        acc_clr     = ac;
        sb.push_back('{res: er, ovf: eo, stamp: ecnt + 3, id: op_id});
        op_id++;
    endtask

    task automatic bubble(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            acc_clr  = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; ena = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        signed_mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Unsigned 15x15 pass-through.
        op(4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 12'h0E1, 1'b0);
        bubble(1);
        // Signed -8x-8, -8x7 back to back.
        op(4'h8, 4'h8, 1'b1, 1'b0, 1'b0, 12'h040, 1'b0);
        op(4'h8, 4'h7, 1'b1, 1'b0, 1'b0, 12'hFC8, 1'b0);
        // Accumulate 3x5 (load), 2x2, 1x1.
        op(4'd3, 4'd5, 1'b0, 1'b1, 1'b1, 12'd15, 1'b0);
        op(4'd2, 4'd2, 1'b0, 1'b1, 1'b0, 12'd19, 1'b0);
        op(4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 12'd20, 1'b0);
        // acc_clr without acc_en is ignored: accumulator still 20 afterwards.
        op(4'd3, 4'd3, 1'b0, 1'b0, 1'b1, 12'd9, 1'b0);
        bubble(2);
        op(4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 12'd21, 1'b0);

        // 15x15 accumulated 19 times: 19th sum 4275 wraps to 179 and flags overflow.
        op(4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 12'd225, 1'b0);
        for (int k = 2; k <= 19; k++) begin
            op(4'hF, 4'hF, 1'b0, 1'b1, 1'b0,
               (k == 19) ? 12'h0B3 : ACC_W'(225 * k), (k == 19));
        end
        op(4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 12'd180, 1'b1);
        op(4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 12'd4, 1'b1);
        bubble(4);

        // Reset with three operations in flight.
        op(4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
        op(4'd3, 4'd4, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
        op(4'd5, 4'd6, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", 32'(out_result), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // Accumulator and flag cleared by reset.
        op(4'd2, 4'd3, 1'b0, 1'b1, 1'b0, 12'd6, 1'b0);

        // Mixed signedness: each add uses its own extension and overflow rule.
        op(4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 12'h0E1, 1'b0);
        op(4'hF, 4'h1, 1'b1, 1'b1, 1'b0, 12'h0E0, 1'b0);
        op(4'hF, 4'h1, 1'b0, 1'b1, 1'b0, 12'h0EF, 1'b0);
        op(4'h8, 4'h7, 1'b1, 1'b1, 1'b1, 12'hFC8, 1'b0);
        op(4'h8, 4'h7, 1'b1, 1'b1, 1'b0, 12'hF90, 1'b0);
        bubble(3);

        // Two-cycle stall with operations in flight.
        op(4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 12'd6, 1'b0);
        op(4'd4, 4'd4, 1'b0, 1'b0, 1'b0, 12'd16, 1'b0);
        op(4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 12'd25, 1'b0);
        @(posedge clk);
        #1;
        ena      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_result", 32'(out_result), 32'd6);
        end
        ena = 1'b1;
        bubble(1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_pending", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
